// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the DMA arbiter and its surroundings.
// The software request pins exist only when DMA_SW_REQUEST_EN is defined.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic [3:0] MaskReg;
    logic [7:0] CommandReg;
    logic       MasterClear;
    logic       Hlda;
    logic       nEOP;
`ifdef DMA_SW_REQUEST_EN
    logic       ReqRegLoad;
    logic [2:0] ReqRegData;
`endif
    logic [1:0] ReqID;
    logic       ValidReqID;
    logic [3:0] DACK;
    logic [3:0] ReqStatus;

    modport master (
        output DREQ, MaskReg, CommandReg, MasterClear, Hlda, nEOP,
`ifdef DMA_SW_REQUEST_EN
        output ReqRegLoad, ReqRegData,
`endif
        input  ReqID, ValidReqID, DACK, ReqStatus
    );

    modport slave (
        input  DREQ, MaskReg, CommandReg, MasterClear, Hlda, nEOP,
`ifdef DMA_SW_REQUEST_EN
        input  ReqRegLoad, ReqRegData,
`endif
        output ReqID, ValidReqID, DACK, ReqStatus
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: DREQ sync, mask/polarity, fixed or rotating priority, DACK.
// Define DMA_SW_REQUEST_EN to add the software request register (ignores MaskReg).
module dma_priority_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4
) (
    input logic                    Clock,
    input logic                    nReset,
    dma_priority_arbiter_if.slave  bus
);
    if (NUM_CH != 4) begin : g_bad_num_ch
        $error("dma_priority_arbiter: NUM_CH must be 4");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("dma_priority_arbiter: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic [1:0] {IDLE, GRANT, SERVICE, RELEASE} state_t;

    state_t     state, state_next;
    logic [1:0] req_id, req_id_next;
    logic [1:0] prio;
    logic [1:0] winner;
    logic [3:0] req_status;
    logic [3:0] eligible;
    logic [3:0] dack_active;
    logic [3:0] sync_q [SYNC_STAGES-1];
    logic       unused_cmd;

    assign unused_cmd = ^{bus.CommandReg[5], bus.CommandReg[3], bus.CommandReg[1:0]};

    // Polarity is applied in the last sync flop so ReqStatus resets to 0 in either polarity.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < SYNC_STAGES-1; i++) sync_q[i] <= '0;
            req_status <= '0;
        end else if (bus.MasterClear) begin
            for (int i = 0; i < SYNC_STAGES-1; i++) sync_q[i] <= '0;
            req_status <= '0;
        end else begin
            sync_q[0] <= bus.DREQ;
            for (int i = 1; i < SYNC_STAGES-1; i++) sync_q[i] <= sync_q[i-1];
            req_status <= sync_q[SYNC_STAGES-2] ^ {4{bus.CommandReg[6]}};
        end
    end

`ifdef DMA_SW_REQUEST_EN
    logic [3:0] sw_req;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sw_req <= '0;
        end else if (bus.MasterClear) begin
            sw_req <= '0;
        end else begin
            if (state == SERVICE && !bus.nEOP) sw_req[req_id] <= 1'b0;
            if (bus.ReqRegLoad) sw_req[bus.ReqRegData[1:0]] <= bus.ReqRegData[2];
        end
    end

    always_comb begin
        eligible = (req_status & ~bus.MaskReg) | sw_req;
        if (bus.CommandReg[2]) eligible = '0;
    end
`else
    always_comb begin
        eligible = req_status & ~bus.MaskReg;
        if (bus.CommandReg[2]) eligible = '0;
    end
`endif

    // Scan from the lowest-priority offset upward so the highest-priority hit is written last.
    always_comb begin
        logic [1:0] base;
        logic [1:0] idx;
        winner = '0;
        base   = bus.CommandReg[4] ? prio : 2'd0;
        idx    = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (eligible[idx]) winner = idx;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            req_id <= '0;
            prio   <= '0;
        end else if (bus.MasterClear) begin
            state  <= IDLE;
            req_id <= '0;
            prio   <= '0;
        end else begin
            state  <= state_next;
            req_id <= req_id_next;
            if (state == RELEASE) prio <= req_id + 2'd1;
        end
    end

    always_comb begin
        state_next  = state;
        req_id_next = req_id;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    req_id_next = winner;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (!eligible[req_id])  state_next = IDLE;
                else if (bus.Hlda)      state_next = SERVICE;
            end
            SERVICE: begin
                if (!bus.nEOP || !bus.Hlda) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dack_active    = (state == SERVICE) ? (4'b0001 << req_id) : 4'b0000;
    assign bus.DACK       = bus.CommandReg[7] ? dack_active : ~dack_active;
    assign bus.ValidReqID = (state == GRANT) || (state == SERVICE);
    assign bus.ReqID      = req_id;
    assign bus.ReqStatus  = req_status;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter (default SYNC_STAGES = 2).
// Expected values are hand-derived from the arbiter's documented behaviour.
module tb_dma_priority_arbiter;
    logic Clock;
    logic nReset;
    int   total_checks = 0;
    int   bad_checks   = 0;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter #(.SYNC_STAGES(2), .NUM_CH(4)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dreq, input logic [3:0] mask, input logic [7:0] cmd);
        bus.DREQ       = dreq;
        bus.MaskReg    = mask;
        bus.CommandReg = cmd;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.ValidReqID !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        checkOutput(tag, {3'b000, bus.ValidReqID}, 4'd1);
    endtask

    // One full grant/service/release of the expected channel with active-low DACK.
    task automatic serve_channel(input logic [1:0] exp_id);
        wait_valid("rot_valid");
        checkOutput("rot_id", {2'b00, bus.ReqID}, {2'b00, exp_id});
        bus.Hlda = 1'b1;
        tick(1);
        checkOutput("rot_dack", bus.DACK, ~(4'b0001 << exp_id));
        bus.nEOP = 1'b0;
        tick(1);
        checkOutput("rot_release", {3'b000, bus.ValidReqID}, 4'd0);
        bus.nEOP = 1'b1;
        bus.Hlda = 1'b0;
    endtask

    initial begin
        logic [3:0] dack_seen;
        nReset          = 1'b0;
        bus.MasterClear = 1'b0;
        bus.Hlda        = 1'b0;
        bus.nEOP        = 1'b1;
`ifdef DMA_SW_REQUEST_EN
        bus.ReqRegLoad  = 1'b0;
        bus.ReqRegData  = 3'b000;
`endif
        applyStimulus(4'b0000, 4'b0000, 8'h00);
        tick(2);
        checkOutput("rst_valid",  {3'b000, bus.ValidReqID}, 4'd0);
        checkOutput("rst_id",     {2'b00, bus.ReqID}, 4'd0);
        checkOutput("rst_dack",   bus.DACK, 4'b1111);
        checkOutput("rst_status", bus.ReqStatus, 4'b0000);
        bus.CommandReg = 8'h80;
        #1;
        checkOutput("rst_dack_hi", bus.DACK, 4'b0000);
        bus.CommandReg = 8'h00;
        @(negedge Clock);
        nReset = 1'b1;
        tick(1);

        $display("[TB] fixed priority");
        applyStimulus(4'b1010, 4'b0000, 8'h00);
        tick(2);
        checkOutput("fix_status", bus.ReqStatus, 4'b1010);
        checkOutput("fix_latency", {3'b000, bus.ValidReqID}, 4'd0);
        tick(1);
        checkOutput("fix_valid", {3'b000, bus.ValidReqID}, 4'd1);
        checkOutput("fix_id",    {2'b00, bus.ReqID}, 4'd1);
        checkOutput("fix_dack_grant", bus.DACK, 4'b1111);
        bus.Hlda = 1'b1;
        tick(1);
        checkOutput("fix_dack_svc", bus.DACK, 4'b1101);
        bus.DREQ = 4'b1011;
        tick(3);
        checkOutput("fix_no_preempt_id",   {2'b00, bus.ReqID}, 4'd1);
        checkOutput("fix_no_preempt_dack", bus.DACK, 4'b1101);
        bus.DREQ = 4'b1010;
        tick(3);
        bus.nEOP = 1'b0;
        tick(1);
        checkOutput("fix_rel_valid", {3'b000, bus.ValidReqID}, 4'd0);
        checkOutput("fix_rel_dack",  bus.DACK, 4'b1111);
        bus.nEOP = 1'b1;
        bus.Hlda = 1'b0;
        tick(1);
        checkOutput("fix_idle_valid", {3'b000, bus.ValidReqID}, 4'd0);
        tick(1);
        checkOutput("fix_regrant_valid", {3'b000, bus.ValidReqID}, 4'd1);
        checkOutput("fix_regrant_id",    {2'b00, bus.ReqID}, 4'd1);

        $display("[TB] master clear during grant");
        bus.MasterClear = 1'b1;
        tick(1);
        checkOutput("mc_valid",  {3'b000, bus.ValidReqID}, 4'd0);
        checkOutput("mc_status", bus.ReqStatus, 4'b0000);
        bus.MasterClear = 1'b0;
        bus.DREQ        = 4'b0000;
        tick(3);
        checkOutput("mc_quiet", {3'b000, bus.ValidReqID}, 4'd0);

        $display("[TB] rotating priority");
        applyStimulus(4'b1111, 4'b0000, 8'h10);
        for (int k = 0; k < 5; k++) serve_channel(2'(k % 4));

        $display("[TB] withdrawn request");
        applyStimulus(4'b0000, 4'b0000, 8'h10);
        tick(5);
        checkOutput("wd_quiet", {3'b000, bus.ValidReqID}, 4'd0);
        bus.DREQ = 4'b0100;
        wait_valid("wd_valid");
        checkOutput("wd_id", {2'b00, bus.ReqID}, 4'd2);
        bus.DREQ  = 4'b0000;
        dack_seen = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            dack_seen = dack_seen | ~bus.DACK;
        end
        checkOutput("wd_dropped", {3'b000, bus.ValidReqID}, 4'd0);
        checkOutput("wd_no_dack", dack_seen, 4'b0000);
        bus.DREQ = 4'b1111;
        wait_valid("wd_ptr_valid");
        checkOutput("wd_ptr_id", {2'b00, bus.ReqID}, 4'd1);

        $display("[TB] async reset mid-service");
        bus.DREQ = 4'b1000;
        tick(3);
        checkOutput("ar_withdraw", {3'b000, bus.ValidReqID}, 4'd0);
        wait_valid("ar_valid");
        checkOutput("ar_id", {2'b00, bus.ReqID}, 4'd3);
        bus.Hlda = 1'b1;
        tick(1);
        checkOutput("ar_dack_svc", bus.DACK, 4'b0111);
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("ar_dack_now",  bus.DACK, 4'b1111);
        checkOutput("ar_valid_now", {3'b000, bus.ValidReqID}, 4'd0);
        bus.Hlda = 1'b0;
        @(negedge Clock);
        nReset   = 1'b1;
        bus.DREQ = 4'b1111;
        wait_valid("ar_ptr_valid");
        checkOutput("ar_ptr_id", {2'b00, bus.ReqID}, 4'd0);

        $display("[TB] polarity and mask");
        applyStimulus(4'b1110, 4'b1111, 8'hC0);
        tick(4);
        checkOutput("pol_status", bus.ReqStatus, 4'b0001);
        bus.MaskReg = 4'b0001;
        tick(3);
        checkOutput("pol_masked", {3'b000, bus.ValidReqID}, 4'd0);
        bus.MaskReg = 4'b0000;
        tick(1);
        checkOutput("pol_valid", {3'b000, bus.ValidReqID}, 4'd1);
        checkOutput("pol_id",    {2'b00, bus.ReqID}, 4'd0);
        checkOutput("pol_dack_grant", bus.DACK, 4'b0000);
        bus.Hlda = 1'b1;
        tick(1);
        checkOutput("pol_dack_svc", bus.DACK, 4'b0001);
        bus.CommandReg = 8'h40;
        #1;
        checkOutput("pol_dack_flip", bus.DACK, 4'b1110);
        bus.Hlda = 1'b0;
        bus.nEOP = 1'b0;
        tick(1);
        checkOutput("both_rel_valid", {3'b000, bus.ValidReqID}, 4'd0);
        bus.nEOP = 1'b1;
        tick(1);
        checkOutput("both_idle_valid", {3'b000, bus.ValidReqID}, 4'd0);
        tick(1);
        checkOutput("both_regrant", {3'b000, bus.ValidReqID}, 4'd1);

        $display("[TB] controller disable");
        bus.CommandReg = 8'h44;
        tick(1);
        checkOutput("dis_grant_drop", {3'b000, bus.ValidReqID}, 4'd0);
        bus.CommandReg = 8'h40;
        wait_valid("dis_valid");
        bus.Hlda = 1'b1;
        tick(1);
        bus.CommandReg = 8'h44;
        tick(2);
        checkOutput("dis_svc_valid", {3'b000, bus.ValidReqID}, 4'd1);
        checkOutput("dis_svc_dack",  bus.DACK, 4'b1110);
        bus.Hlda = 1'b0;
        tick(1);
        checkOutput("dis_release", {3'b000, bus.ValidReqID}, 4'd0);
        tick(3);
        checkOutput("dis_quiet", {3'b000, bus.ValidReqID}, 4'd0);

`ifdef DMA_SW_REQUEST_EN
        $display("[TB] software request");
        bus.MasterClear = 1'b1;
        tick(1);
        bus.MasterClear = 1'b0;
        applyStimulus(4'b0000, 4'b1111, 8'h00);
        bus.ReqRegData  = 3'b110;
        bus.ReqRegLoad  = 1'b1;
        tick(1);
        bus.ReqRegLoad  = 1'b0;
        wait_valid("sw_valid");
        checkOutput("sw_id", {2'b00, bus.ReqID}, 4'd2);
        bus.Hlda = 1'b1;
        tick(1);
        checkOutput("sw_dack", bus.DACK, 4'b1011);
        bus.nEOP = 1'b0;
        tick(1);
        bus.nEOP = 1'b1;
        bus.Hlda = 1'b0;
        tick(4);
        checkOutput("sw_cleared", {3'b000, bus.ValidReqID}, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
